// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group size,
// per-stage control record and the pipeline-depth helper.
package cla_pkg;

  localparam int GROUP = 4;

  // Control half of the per-stage record; the sum slice lives beside it
  // because its width grows stage by stage.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  // Returns 0 for an illegal WIDTH/SLICE pair so the top can refuse to elaborate.
  function automatic int calc_nslice(input int width, input int slice);
    if (slice <= 0 || (slice % GROUP) != 0 || (width % slice) != 0) return 0;
    return width / slice;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead block: 4-bit group generate/propagate
// feeding a second-level group carry. p_out/g_out let a tree reuse the slice.
module cla_slice
  import cla_pkg::*;
#(
  parameter int SLICE = 64
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb,
  output logic             p_out,
  output logic             g_out
);

  localparam int NG = SLICE / GROUP;

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;
  logic [NG-1:0]    gp;
  logic [NG-1:0]    gg;
  logic [NG:0]      gc;

  assign p = a ^ b;
  assign g = a & b;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gp = '0;
    gg = '0;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[GROUP*j +: GROUP];
      gg[j] = g[GROUP*j+3]
            | (p[GROUP*j+3] & g[GROUP*j+2])
            | (p[GROUP*j+3] & p[GROUP*j+2] & g[GROUP*j+1])
            | (p[GROUP*j+3] & p[GROUP*j+2] & p[GROUP*j+1] & g[GROUP*j]);
    end
  end

  always_comb begin
    gc    = '0;
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
  end

  // Bit carries inside each group come straight from the group carry-in.
  always_comb begin
    c = '0;
    for (int j = 0; j < NG; j++) begin
      c[GROUP*j]   = gc[j];
      c[GROUP*j+1] = g[GROUP*j] | (p[GROUP*j] & gc[j]);
      c[GROUP*j+2] = g[GROUP*j+1]
                   | (p[GROUP*j+1] & g[GROUP*j])
                   | (p[GROUP*j+1] & p[GROUP*j] & gc[j]);
      c[GROUP*j+3] = g[GROUP*j+2]
                   | (p[GROUP*j+2] & g[GROUP*j+1])
                   | (p[GROUP*j+2] & p[GROUP*j+1] & g[GROUP*j])
                   | (p[GROUP*j+2] & p[GROUP*j+1] & p[GROUP*j] & gc[j]);
    end
    c[SLICE] = gc[NG];
  end

  always_comb begin
    g_out = 1'b0;
    for (int j = 0; j < NG; j++) begin
      g_out = gg[j] | (gp[j] & g_out);
    end
  end

  assign p_out = &gp;
  assign sum   = p ^ c[SLICE-1:0];
  assign cout  = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit carry-lookahead adder, one SLICE per stage, global stall.
// Define CLA_PIPE_SUB_EN to add the 'sub' port (a-b when sub=1).
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int SLICE = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = calc_nslice(WIDTH, SLICE);

  if (NSLICE < 1) begin : g_bad_cfg
    $error("cla_pipe_adder: SLICE must divide WIDTH and be a multiple of 4");
  end

  logic             advance;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             ovf_d;
  logic             ovf_q;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Subtraction is folded in before stage 0, so the inverted b travels down the skew.
`ifdef CLA_PIPE_SUB_EN
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub | cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  // Operand skew: g_fwd[k] holds the slices still to be consumed by stages k+1 and up.
  for (genvar k = 0; k < NSLICE - 1; k++) begin : g_fwd
    localparam int LO = (k + 1) * SLICE;

    logic [WIDTH-1:LO] a_d, a_q;
    logic [WIDTH-1:LO] b_d, b_q;

    if (k == 0) begin : g_src
      always_comb begin
        a_d = a[WIDTH-1:LO];
        b_d = b_in[WIDTH-1:LO];
      end
    end else begin : g_src
      always_comb begin
        a_d = g_fwd[k-1].a_q[WIDTH-1:LO];
        b_d = g_fwd[k-1].b_q[WIDTH-1:LO];
      end
    end

    // NOTE: pure datapath flops carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
      if (advance) begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    localparam int LO = k * SLICE;
    localparam int HI = LO + SLICE - 1;

    logic [SLICE-1:0] a_s, b_s, sum_s;
    logic             c_in_s, v_in_s, cout_s, c_msb_s, p_s, g_s;
    logic [HI:0]      sum_d, sum_q;
    stage_ctrl_t      ctrl_d, ctrl_q;
    logic             unused_pg;

    if (k == 0) begin : g_src
      always_comb begin
        a_s    = a[HI:LO];
        b_s    = b_in[HI:LO];
        c_in_s = cin_in;
        v_in_s = in_valid;
        sum_d  = sum_s;
      end
    end else begin : g_src
      always_comb begin
        a_s    = g_fwd[k-1].a_q[HI:LO];
        b_s    = g_fwd[k-1].b_q[HI:LO];
        c_in_s = g_stage[k-1].ctrl_q.carry;
        v_in_s = g_stage[k-1].ctrl_q.valid;
        sum_d  = {sum_s, g_stage[k-1].sum_q};
      end
    end

    cla_slice #(.SLICE(SLICE)) u_slice (
      .a     (a_s),
      .b     (b_s),
      .cin   (c_in_s),
      .sum   (sum_s),
      .cout  (cout_s),
      .c_msb (c_msb_s),
      .p_out (p_s),
      .g_out (g_s)
    );

    always_comb begin
      ctrl_d.valid = v_in_s;
      ctrl_d.carry = cout_s;
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctrl_q <= '0;
        sum_q  <= '0;
      end else if (advance) begin
        ctrl_q <= ctrl_d;
        sum_q  <= sum_d;
      end
    end

    assign unused_pg = ^{p_s, g_s, c_msb_s};
  end

  // Overflow compares the carry into the MSB with the carry out of the last slice.
  always_comb begin
    ovf_d = g_stage[NSLICE-1].c_msb_s ^ g_stage[NSLICE-1].cout_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = g_stage[NSLICE-1].ctrl_q.valid;
  assign cout      = g_stage[NSLICE-1].ctrl_q.carry;
  assign sum       = g_stage[NSLICE-1].sum_q;
  assign ovf       = ovf_q;

endmodule
